// File: rtl/bw_clk_cl_pkg.sv
// Shared encodings and parameter limits for the clock-cluster header.
package bw_clk_cl_pkg;

  localparam int NUM_CL_MIN     = 1;
  localparam int NUM_CL_MAX     = 8;
  localparam int SYNC_DEPTH_MIN = 2;
  localparam int SYNC_DEPTH_MAX = 4;
  localparam int STAGGER_MAX    = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Release counter must reach the last cluster's offset plus one saturation step.
  function automatic int rel_cnt_w(input int num_cl, input int stagger);
    return $clog2((num_cl - 1) * stagger + 2);
  endfunction

endpackage

// File: rtl/bw_clk_cl_sync.sv
// Scan-muxed synchronizer chain with async clear; q is the last flop.
module bw_clk_cl_sync
  import bw_clk_cl_pkg::*;
#(
  parameter int DEPTH = SYNC_DEPTH_MIN
)(
  input  logic gclk,
  input  logic clr_l,
  input  logic d,
  input  logic si,
  input  logic se,
  output logic q
);

  logic [DEPTH-1:0] r_chain;
  logic             w_in;

  assign w_in = se ? si : d;

  always_ff @(posedge gclk or negedge clr_l) begin
    if (!clr_l) r_chain <= '0;
    else        r_chain <= {r_chain[DEPTH-2:0], w_in};
  end

  assign q = r_chain[DEPTH-1];

endmodule

// File: rtl/bw_clk_cl_multi_hdr.sv
// Multi-cluster clock header: synchronized staggered reset release,
// per-cluster debug init and latch-based glitch-free clock gates.
module bw_clk_cl_multi_hdr
  import bw_clk_cl_pkg::*;
#(
  parameter int NUM_CL     = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int STAGGER    = 2
)(
  input  logic              gclk,
  input  logic              arst_l,
  input  logic              grst_l,
  input  logic              adbginit_l,
  input  logic              gdbginit_l,
  input  logic [NUM_CL-1:0] cluster_cken,
  input  logic              si,
  input  logic              se,
  output logic [NUM_CL-1:0] rclk,
  output logic [NUM_CL-1:0] cluster_grst_l,
  output logic [NUM_CL-1:0] dbginit_l,
  output logic              so,
  output logic              rst_done
);

  localparam int LAST = (NUM_CL - 1) * STAGGER;
  localparam int CW   = rel_cnt_w(NUM_CL, STAGGER);

  if (NUM_CL < NUM_CL_MIN || NUM_CL > NUM_CL_MAX ||
      SYNC_DEPTH < SYNC_DEPTH_MIN || SYNC_DEPTH > SYNC_DEPTH_MAX ||
      STAGGER < 0 || STAGGER > STAGGER_MAX) begin : g_bad_param
    $error("bw_clk_cl_multi_hdr: parameter out of range");
  end

  logic              w_grst_sync;
  logic              w_dbg_sync;
  logic              w_dbg_clr_l;
  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [NUM_CL-1:0] r_cgrst;
  logic [NUM_CL-1:0] r_dbginit;
  logic              r_done;

  // The dbg chain also carries scan-out, so it must clear on the main reset too.
  assign w_dbg_clr_l = arst_l & adbginit_l;

  bw_clk_cl_sync #(.DEPTH(SYNC_DEPTH)) u_grst_sync (
    .gclk(gclk), .clr_l(arst_l), .d(grst_l), .si(si), .se(se), .q(w_grst_sync)
  );

  bw_clk_cl_sync #(.DEPTH(SYNC_DEPTH)) u_dbg_sync (
    .gclk(gclk), .clr_l(w_dbg_clr_l), .d(gdbginit_l), .si(w_grst_sync), .se(se), .q(w_dbg_sync)
  );

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (!se) begin
      if (!w_grst_sync) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end
          ST_RUN: begin
            if (r_cnt != CW'(LAST + 1)) r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(LAST))     r_state <= ST_DONE;
          end
          default: r_state <= ST_DONE;
        endcase
      end
    end
  end

  // Releases are decoded from the registered state, so an abort drops them one edge after IDLE.
  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      r_cgrst <= '0;
      r_done  <= 1'b0;
    end else if (!se) begin
      for (int i = 0; i < NUM_CL; i++)
        r_cgrst[i] <= (r_state != ST_IDLE) && (r_cnt >= CW'(i * STAGGER));
      r_done <= (r_state != ST_IDLE) && (r_cnt >= CW'(LAST));
    end
  end

  always_ff @(posedge gclk or negedge adbginit_l) begin
    if (!adbginit_l) r_dbginit <= '0;
    else             r_dbginit <= r_cgrst & {NUM_CL{w_dbg_sync}};
  end

  for (genvar i = 0; i < NUM_CL; i++) begin : g_cl
    logic r_cken_lat;
    // Transparent while gclk is low so the enable can only change outside a pulse.
    always_latch begin
      if (!arst_l)    r_cken_lat <= 1'b1;
      else if (!gclk) r_cken_lat <= cluster_cken[i] | se;
    end
    assign rclk[i] = gclk & r_cken_lat;
  end

  assign cluster_grst_l = r_cgrst;
  assign dbginit_l      = r_dbginit;
  assign rst_done       = r_done;
  assign so             = w_dbg_sync;

endmodule
